// File: rtl/updown_event_counter_if.sv
// Button inputs, count handshake and LED levels between the event counter and its environment.
interface updown_event_counter_if #(
   parameter int unsigned WIDTH = 12
);
   logic             btn_up;
   logic             btn_down;
   logic             en;
   logic [WIDTH-1:0] count;
   logic             rdy;
   logic [1:0]       pressed;

   modport master (
      input  btn_up, btn_down, en,
      output count, rdy, pressed
   );

   modport slave (
      output btn_up, btn_down, en,
      input  count, rdy, pressed
   );
endinterface

// File: rtl/updown_event_counter.sv
// Debounced up/down push-button counter with a wrapping count that is offered
// downstream through a one-cycle rdy strobe whenever it changes.
module updown_event_counter #(
   parameter int unsigned WIDTH           = 12,
   parameter int unsigned MAX_COUNT       = 4095,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input logic                  clk,
   input logic                  reset,
   updown_event_counter_if.master bus
);
   localparam int unsigned TW = 24;
   localparam logic [TW-1:0]    TIMER_LAST = TW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] COUNT_MAX  = WIDTH'(MAX_COUNT);

   typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} dbnc_state_e;

   // Index 0 is the up button, index 1 the down button.
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   dbnc_state_e      state_q [2];
   dbnc_state_e      state_d [2];
   logic [TW-1:0]    timer_q [2];
   logic [TW-1:0]    timer_d [2];
   logic [1:0]       press_q, press_d;
   logic [1:0]       pressed_q, pressed_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             pending_q, pending_d;
   logic             rdy_q, rdy_d;
   logic [TW-1:0]    timer_inc [2];

   always_comb begin
      sync1_d   = {bus.btn_down, bus.btn_up};
      sync2_d   = sync1_q;
      press_d   = 2'b00;
      pressed_d = 2'b00;
      for (int i = 0; i < 2; i++) begin
         state_d[i]   = state_q[i];
         timer_d[i]   = timer_q[i];
         timer_inc[i] = timer_q[i] + TW'(1);
         unique case (state_q[i])
            IDLE: begin
               if (sync2_q[i]) begin
                  timer_d[i] = '0;
                  state_d[i] = ARM;
               end
            end
            ARM: begin
               if (!sync2_q[i]) begin
                  state_d[i] = IDLE;
               end else begin
                  timer_d[i] = timer_inc[i];
                  if (timer_inc[i] == TIMER_LAST) begin
                     state_d[i] = HELD;
                     press_d[i] = 1'b1;
                  end
               end
            end
            HELD: begin
               if (!sync2_q[i]) begin
                  timer_d[i] = '0;
                  state_d[i] = DISARM;
               end
            end
            DISARM: begin
               if (sync2_q[i]) begin
                  state_d[i] = HELD;
               end else begin
                  timer_d[i] = timer_inc[i];
                  if (timer_inc[i] == TIMER_LAST) begin
                     state_d[i] = IDLE;
                  end
               end
            end
            default: state_d[i] = IDLE;
         endcase
         pressed_d[i] = (state_d[i] == HELD) || (state_d[i] == DISARM);
      end
   end

   // Count update and handshake; a press in the strobe cycle re-arms pending.
   always_comb begin
      count_d   = count_q;
      pending_d = pending_q;
      rdy_d     = 1'b0;
      if (pending_q && bus.en) begin
         rdy_d     = 1'b1;
         pending_d = 1'b0;
      end
      unique case (press_q)
         2'b01: begin
            count_d   = (count_q == COUNT_MAX) ? '0 : count_q + WIDTH'(1);
            pending_d = 1'b1;
         end
         2'b10: begin
            count_d   = (count_q == '0) ? COUNT_MAX : count_q - WIDTH'(1);
            pending_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= 2'b00;
         sync2_q   <= 2'b00;
         press_q   <= 2'b00;
         pressed_q <= 2'b00;
         count_q   <= '0;
         pending_q <= 1'b1;
         rdy_q     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= IDLE;
            timer_q[i] <= '0;
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         press_q   <= press_d;
         pressed_q <= pressed_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         rdy_q     <= rdy_d;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            timer_q[i] <= timer_d[i];
         end
      end
   end

   assign bus.count   = count_q;
   assign bus.rdy     = rdy_q;
   assign bus.pressed = pressed_q;
endmodule

// File: tb/tb_updown_event_counter.sv
// Directed bench for updown_event_counter with a short debounce window:
// a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_updown_event_counter;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   int   rdy_cnt;
   logic [11:0] last_rdy_val;

   updown_event_counter_if #(.WIDTH(12)) bus ();

   updown_event_counter #(
      .WIDTH(12),
      .MAX_COUNT(4095),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
   );

   typedef struct {
      logic        up;
      logic        dn;
      logic        en;
      logic [11:0] cnt;
      logic        rdy;
      logic [1:0]  prs;
   } vec_t;

   vec_t vq[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.rdy === 1'b1) begin
         rdy_cnt      <= rdy_cnt + 1;
         last_rdy_val <= bus.count;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run still going at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic up, input logic dn, input logic en,
                      input logic [11:0] cnt, input logic rdy, input logic [1:0] prs);
      vec_t v;
      v.up = up; v.dn = dn; v.en = en; v.cnt = cnt; v.rdy = rdy; v.prs = prs;
      vq.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic up, input logic dn);
      bus.btn_up   = up;
      bus.btn_down = dn;
      repeat (7) tick();
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      repeat (7) tick();
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      int r0;
      n_vec = 0; n_err = 0; rdy_cnt = 0; last_rdy_val = '0;
      reset = 1'b1;
      bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.en = 1'b1;

      // Bounce: no press ever accepted.
      add(1,0,1, 0,0,2'b00); add(0,0,1, 0,0,2'b00);
      add(1,0,1, 0,0,2'b00); add(0,0,1, 0,0,2'b00);
      for (int i = 0; i < 4; i++) add(0,0,1, 0,0,2'b00);
      // Clean up-press held 10 cycles: count moves on the 7th edge, rdy one edge later.
      for (int i = 0; i < 5; i++) add(1,0,1, 0,0,2'b00);
      add(1,0,1, 0,0,2'b01);
      add(1,0,1, 1,0,2'b01);
      add(1,0,1, 1,1,2'b01);
      add(1,0,1, 1,0,2'b01);
      add(1,0,1, 1,0,2'b01);
      for (int i = 0; i < 5; i++) add(0,0,1, 1,0,2'b01);
      add(0,0,1, 1,0,2'b00);
      add(0,0,1, 1,0,2'b00);

      // Reset values and the single post-reset offer of 0.
      repeat (2) tick();
      check("reset_count", 32'(bus.count), 0);
      check("reset_rdy", 32'(bus.rdy), 0);
      check("reset_pressed", 32'(bus.pressed), 0);
      reset = 1'b0;
      tick();
      check("post_reset_rdy", 32'(bus.rdy), 1);
      check("post_reset_rdy_count", 32'(bus.count), 0);
      r0 = rdy_cnt;
      repeat (4) tick();
      check("idle_rdy", 32'(bus.rdy), 0);
      check("idle_no_more_rdy", 32'(rdy_cnt - r0), 1);

      for (int i = 0; i < vq.size(); i++) begin
         bus.btn_up   = vq[i].up;
         bus.btn_down = vq[i].dn;
         bus.en       = vq[i].en;
         tick();
         check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vq[i].cnt));
         check($sformatf("vec%0d_rdy", i), 32'(bus.rdy), 32'(vq[i].rdy));
         check($sformatf("vec%0d_pressed", i), 32'(bus.pressed), 32'(vq[i].prs));
      end

      // Wrap-around in both directions.
      for (int i = 0; i < 4094; i++) press(1'b1, 1'b0);
      check("wrap_reach_max", 32'(bus.count), 4095);
      press(1'b1, 1'b0);
      check("wrap_up_to_zero", 32'(bus.count), 0);
      press(1'b0, 1'b1);
      check("wrap_down_to_max", 32'(bus.count), 4095);
      check("wrap_down_offered", 32'(last_rdy_val), 4095);

      // Presses with en low accumulate; one offer of the latest value.
      pulse_reset();
      check("rst2_count", 32'(bus.count), 0);
      for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
      check("pre_hold_count", 32'(bus.count), 5);
      bus.en = 1'b0;
      r0 = rdy_cnt;
      for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
      check("en_low_count", 32'(bus.count), 8);
      check("en_low_no_rdy", 32'(rdy_cnt - r0), 0);
      bus.en = 1'b1;
      tick();
      check("en_raise_rdy", 32'(bus.rdy), 1);
      check("en_raise_count", 32'(bus.count), 8);
      tick();
      check("en_raise_rdy_drop", 32'(bus.rdy), 0);
      repeat (3) tick();
      check("en_raise_single_rdy", 32'(rdy_cnt - r0), 1);

      // Simultaneous up and down leave the count alone.
      press(1'b0, 1'b1);
      check("down_to_7", 32'(bus.count), 7);
      r0 = rdy_cnt;
      bus.btn_up = 1'b1; bus.btn_down = 1'b1;
      repeat (6) tick();
      check("both_pressed_leds", 32'(bus.pressed), 3);
      tick();
      bus.btn_up = 1'b0; bus.btn_down = 1'b0;
      repeat (7) tick();
      check("both_count", 32'(bus.count), 7);
      check("both_no_rdy", 32'(rdy_cnt - r0), 0);

      // Reset in the middle of ARM clears everything at once.
      bus.btn_up = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      #1;
      check("midarm_rst_count", 32'(bus.count), 0);
      check("midarm_rst_rdy", 32'(bus.rdy), 0);
      check("midarm_rst_pressed", 32'(bus.pressed), 0);
      bus.btn_up = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("midarm_release_rdy", 32'(bus.rdy), 1);
      check("midarm_release_count", 32'(bus.count), 0);
      repeat (8) tick();
      check("midarm_no_press", 32'(bus.count), 0);
      check("midarm_pressed_idle", 32'(bus.pressed), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/updown_event_counter.md
Name: updown_event_counter

Overview:
Upstream stage of the BCD display chain. It takes two raw push-buttons (up, down), synchronises and debounces each one, and counts accepted presses in a wrapping 12-bit register. It offers each new count to the binary-to-BCD converter with an en/rdy handshake. The block replaces a free-running counter when the display must show user-driven events.

Parameters:
WIDTH, 12, count width in bits (matches the converter input).
MAX_COUNT, 4095, highest count value; must be at most 2^WIDTH-1.
DEBOUNCE_CYCLES, 500000, clk cycles a synchronised button must hold its level before the change is accepted (range 2..2^24-1).

Ports:
clk  input  1  system clock; all logic is on its rising edge.
reset  input  1  asynchronous, active-high reset.
btn_up  input  1  raw, asynchronous up button; active-high.
btn_down  input  1  raw, asynchronous down button; active-high.
en  input  1  downstream is ready to accept a value (the display driver's rdy, chained through).
count  output  WIDTH  current count; changes only on accepted presses.
rdy  output  1  one-cycle strobe: count is valid for the converter to capture.
pressed  output  2  debounced levels {down, up}, for LEDs.

Behaviour:
- Reset (asynchronous, active-high):
  - count=0, rdy=0, pressed=0.
  - All debouncers go to IDLE; synchroniser flops =0; pending=1, so 0 is offered once after reset.
- Synchroniser: each button passes through 2 flip-flops. Every later decision uses the synchronised signal s.
- Debouncer per button, with a 24-bit timer:
  - IDLE (level 0): when s=1, clear the timer and go to ARM.
  - ARM: timer increments each cycle while s=1. If s=0, go to IDLE. If timer reaches DEBOUNCE_CYCLES-1 while s=1, go to HELD and emit a one-cycle press pulse.
  - HELD (level 1): when s=0, clear the timer and go to DISARM.
  - DISARM: timer increments while s=0. If s=1, go to HELD. If timer reaches DEBOUNCE_CYCLES-1, go to IDLE.
  - pressed[i]=1 in HELD and DISARM, otherwise 0.
- Counting on press pulses:
  - Up only: count = (count==MAX_COUNT) ? 0 : count+1.
  - Down only: count = (count==0) ? MAX_COUNT : count-1.
  - Up and down in the same cycle: count is unchanged and pending is not set.
  - The count update is registered: count changes on the cycle after the pulse.
- Handshake:
  - pending is set whenever count changes.
  - rdy=1 for exactly one cycle when pending=1 and en=1; pending clears in that same cycle.
  - If a new press arrives while pending=1, count updates and pending stays 1. Only the latest value is offered; intermediate values are dropped by design.
  - count is stable in the cycle rdy is high.
  - A press in the cycle rdy fires re-sets pending. The next rdy needs en again.
  - While en=0 indefinitely, rdy stays 0 and counting continues.
- Holding a button produces exactly one press; there is no auto-repeat.
- Latency, press to count: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Latency, count to rdy: 1 cycle once en=1.
- Reset asserted mid-debounce or mid-handshake aborts immediately. There is no rdy while reset is high. The first rdy after release carries count=0, once en=1.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
1. Reset release with en=1: rdy pulses once with count=0, then rdy stays 0 while idle.
2. Clean up-press held 10 cycles, en=1: count 0->1 exactly 7 cycles after the input edge. One rdy strobe; pressed[0]=1 during the hold.
3. Bounce: btn_up toggles 1,0,1,0 on consecutive cycles, then 0 → count stays 0, no rdy, pressed=0.
4. Wrap-around: 4095 up-presses plus one more → count 4095 then 0. A down-press from 0 → 4095.
5. en held 0 during three up-presses from 5 → count=8, rdy=0. Raising en → a single rdy with count=8.
6. Up and down pressed in the same cycle from count=7 → count stays 7, no rdy. Reset asserted mid-ARM → all outputs 0 immediately; after release, rdy with count=0.
